move_scorer: RTL

MOVE_SCORER -- requirements
Module: move_scorer

---
 rtl/chess_pkg.sv | 42 ++++
 rtl/mvv_lva_key.sv | 47 ++++
 rtl/move_scorer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings for the move-ordering pipeline.
//
// Contents:
//   piece_e         - piece-type codes (0 = none, 1..6 = P,N,B,R,Q,K)
//   move field map  - bit offsets and widths of from/to/promotion in a move word
//   key constants   - MVV-LVA sort key building blocks
//   scorer_state_e  - move_scorer control FSM states
package chess_pkg;

   typedef enum logic [2:0] {
      PieceNone   = 3'd0,
      PiecePawn   = 3'd1,
      PieceKnight = 3'd2,
      PieceBishop = 3'd3,
      PieceRook   = 3'd4,
      PieceQueen  = 3'd5,
      PieceKing   = 3'd6
   } piece_e;

   // Move word layout: [5:0] from square, [11:6] to square, [14:12] promotion piece.
   localparam int unsigned SqBits    = 6;
   localparam int unsigned PromoBits = 3;
   localparam int unsigned FromLsb   = 0;
   localparam int unsigned ToLsb     = 6;
   localparam int unsigned PromoLsb  = 12;
   localparam int unsigned MoveBits  = PromoLsb + PromoBits;

   // Sort key building blocks; higher keys are searched first.
   localparam logic [7:0] KeyCapture      = 8'h80;
   localparam logic [7:0] KeyPromoCapture = 8'h40;
   localparam logic [7:0] KeyQuietPromo   = 8'h70;
   localparam logic [7:0] KeyKiller       = 8'h60;
   localparam logic [7:0] KeyQuiet        = 8'h10;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StDrain,
      StDone
   } scorer_state_e;

endpackage

// File: rtl/mvv_lva_key.sv
// Combinational MVV-LVA sort key for one move.
//
// Ports:
//   attacker_i   - moving piece type (1..6)
//   victim_i     - captured piece type, 0 for a quiet move
//   promo_i      - promotion piece, 0 for none
//   killer_hit_i - move matched the current killer move
//   key_o        - 8-bit sort key
//
// Captures rank by most valuable victim, then least valuable attacker; a
// capturing promotion is lifted above all plain captures. Among quiet moves,
// promotions outrank the killer, which outranks everything else. The killer
// flag is ignored for captures.
module mvv_lva_key
   import chess_pkg::*;
(
   input  logic [2:0]           attacker_i,
   input  logic [2:0]           victim_i,
   input  logic [PromoBits-1:0] promo_i,
   input  logic                 killer_hit_i,
   output logic [7:0]           key_o
);

   logic [2:0] lva;
   logic       is_capture;
   logic       is_promo;

   // Cheaper attackers get larger low bits so PxQ sorts above QxQ.
   assign lva        = 3'd7 - attacker_i;
   assign is_capture = (victim_i != PieceNone);
   assign is_promo   = (promo_i != '0);

   always_comb begin
      key_o = KeyQuiet;
      if (is_capture) begin
         key_o = KeyCapture | {2'b00, victim_i, lva};
         if (is_promo) begin
            key_o = key_o + KeyPromoCapture;
         end
      end else if (is_promo) begin
         key_o = KeyQuietPromo + 8'(promo_i);
      end else if (killer_hit_i) begin
         key_o = KeyKiller;
      end
   end

endmodule

// File: rtl/move_scorer.sv
// Move scorer: accepts a batch of generated moves, attaches an MVV-LVA sort key
// to each and pushes (move, key) pairs into an external sorter.
//
// Ports:
//   clk_in, rst_in          - clock, asynchronous active-low reset
//   start_in                - begin a new batch (honoured only when idle)
//   move_in, attacker_in,
//   victim_in, last_in,
//   valid_in / ready_out    - move beat stream; ready only while collecting
//   killer_in,
//   killer_valid_in         - current killer move for quiet-move promotion
//   value_out, key_out,
//   valid_out               - push to the sorter, two cycles after acceptance
//   sorter_clear_out        - one-cycle sorter clear when a batch starts
//   busy_out                - batch in progress; sorter must not be dequeued
//   batch_done_out          - one-cycle pulse once every push has left
//   overflow_out            - sticky: at least one beat dropped for capacity
//   count_out               - moves pushed in the current batch
//
// Pipeline: stage 1 registers the beat and the killer match, stage 2 registers
// the computed key. There is no backpressure towards the sorter.
module move_scorer
   import chess_pkg::*;
#(
   parameter int unsigned KEY_BITS   = 8,
   parameter int unsigned VALUE_BITS = 15,
   parameter int unsigned MAX_LEN    = 32
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic [VALUE_BITS-1:0]        move_in,
   input  logic [2:0]                   attacker_in,
   input  logic [2:0]                   victim_in,
   input  logic                         last_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [VALUE_BITS-1:0]        killer_in,
   input  logic                         killer_valid_in,
   output logic [VALUE_BITS-1:0]        value_out,
   output logic [KEY_BITS-1:0]          key_out,
   output logic                         valid_out,
   output logic                         sorter_clear_out,
   output logic                         busy_out,
   output logic                         batch_done_out,
   output logic                         overflow_out,
   output logic [$clog2(MAX_LEN+1)-1:0] count_out
);

   localparam int unsigned   CntBits = $clog2(MAX_LEN + 1);
   localparam logic [CntBits-1:0] CntMax = CntBits'(MAX_LEN);
   localparam logic [CntBits-1:0] CntOne = CntBits'(1);

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   scorer_state_e state_q, state_d;

   logic accept;     // beat handshake this cycle
   logic drop;       // accepted beat that would exceed sorter capacity
   logic admit;      // accepted beat that enters the pipeline
   logic clear;      // batch start
   logic pipe_empty;

   logic s1_valid_q;
   logic s2_valid_q;

   // Admission is limited by beats already sent into the pipeline rather than
   // by count_out, which lags two cycles and would let in-flight beats slip
   // past the capacity limit.
   logic [CntBits-1:0] admit_q, admit_d;
   logic [CntBits-1:0] count_q, count_d;
   logic               ovf_q, ovf_d;

   assign accept     = valid_in && (state_q == StCollect);
   assign drop       = accept && (admit_q == CntMax);
   assign admit      = accept && !drop;
   assign pipe_empty = !s1_valid_q && !s2_valid_q;

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_in) begin
               state_d = StCollect;
               clear   = 1'b1;
            end
         end
         StCollect: begin
            // A dropped last beat still closes the batch.
            if (accept && last_in) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pipe_empty) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Batch counters and overflow flag
   // ---------------------------------------------------------------------------
   always_comb begin
      admit_d = admit_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear) begin
         admit_d = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         if (drop) begin
            ovf_d = 1'b1;
         end
         if (admit) begin
            admit_d = admit_q + CntOne;
         end
         if (s2_valid_q && (count_q != CntMax)) begin
            count_d = count_q + CntOne;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         admit_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         admit_q <= admit_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: register the beat fields and the killer match
   // ---------------------------------------------------------------------------
   logic [SqBits-1:0]    s1_from_q;
   logic [SqBits-1:0]    s1_to_q;
   logic [PromoBits-1:0] s1_promo_q;
   logic [2:0]           s1_att_q;
   logic [2:0]           s1_vic_q;
   logic                 s1_killer_q;
   logic                 killer_match;

   assign killer_match = killer_valid_in && (move_in == killer_in);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         s1_valid_q  <= 1'b0;
         s1_from_q   <= '0;
         s1_to_q     <= '0;
         s1_promo_q  <= '0;
         s1_att_q    <= '0;
         s1_vic_q    <= '0;
         s1_killer_q <= 1'b0;
      end else begin
         s1_valid_q <= admit;
         if (admit) begin
            s1_from_q   <= move_in[FromLsb +: SqBits];
            s1_to_q     <= move_in[ToLsb +: SqBits];
            s1_promo_q  <= move_in[PromoLsb +: PromoBits];
            s1_att_q    <= attacker_in;
            s1_vic_q    <= victim_in;
            s1_killer_q <= killer_match;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: compute and register the key
   // ---------------------------------------------------------------------------
   logic [7:0]            key_d;
   logic [VALUE_BITS-1:0] s2_value_q;
   logic [KEY_BITS-1:0]   s2_key_q;

   mvv_lva_key u_key (
      .attacker_i   (s1_att_q),
      .victim_i     (s1_vic_q),
      .promo_i      (s1_promo_q),
      .killer_hit_i (s1_killer_q),
      .key_o        (key_d)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         s2_valid_q <= 1'b0;
         s2_value_q <= '0;
         s2_key_q   <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_value_q <= VALUE_BITS'({s1_promo_q, s1_to_q, s1_from_q});
            s2_key_q   <= KEY_BITS'(key_d);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ready_out        = (state_q == StCollect);
   assign busy_out         = (state_q != StIdle);
   assign batch_done_out   = (state_q == StDone);
   assign sorter_clear_out = clear;
   assign overflow_out     = ovf_q;
   assign count_out        = count_q;
   assign valid_out        = s2_valid_q;
   assign value_out        = s2_value_q;
   assign key_out          = s2_key_q;

endmodule
